controlador_interrupcao: RTL and testbench

CONTROLADOR_INTERRUPCAO -- requirements
Module: controlador_interrupcao

---
 rtl/controlador_interrupcao.sv | 124 ++++++++++++
 tb/tb_controlador_interrupcao.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_interrupcao.sv
// Interrupt controller: edge-latched pending bits, maskable fixed-priority
// selection (bit 0 highest) and a request/handle handshake with the control unit.
module controlador_interrupcao #(
  parameter int unsigned N_FONTES   = 4,
  parameter int unsigned LARGURA_PC = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_FONTES-1:0]   reqInterrupcao,
  input  logic                  escreveMascara,
  input  logic [N_FONTES-1:0]   dadoMascara,
  input  logic                  habilitaInterrupcao,
  input  logic [LARGURA_PC-1:0] valorPC,
  input  logic                  ackInterrupcao,
  input  logic                  fimInterrupcao,
  output logic                  pedidoInterrupcao,
  output logic                  emTratamento,
  output logic [LARGURA_PC-1:0] valorPCBuffer,
  output logic [31:0]           qualInterrupcao
);

  localparam int unsigned LARGURA_ID = (N_FONTES > 1) ? $clog2(N_FONTES) : 1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    PEDINDO  = 2'd1,
    TRATANDO = 2'd2
  } estado_t;

  estado_t                 estado, estado_prox;
  logic [N_FONTES-1:0]     req_prev;
  logic [N_FONTES-1:0]     pendente;
  logic [N_FONTES-1:0]     mascara;
  logic [N_FONTES-1:0]     borda;
  logic [N_FONTES-1:0]     elegivel;
  logic [N_FONTES-1:0]     limpa;
  logic [LARGURA_ID-1:0]   id_atual, id_prox;
  logic                    armado;
  logic                    carrega_id, aceita, finaliza;

  // The first clock after reset only records the baseline level, so a
  // request already high at release is not taken as an edge.
  assign borda    = armado ? (reqInterrupcao & ~req_prev) : '0;
  assign elegivel = pendente & mascara;
  assign limpa    = aceita ? (N_FONTES'(1) << id_atual) : '0;

  // Lowest-index eligible source wins
  always_comb begin
    id_prox = '0;
    for (int i = int'(N_FONTES) - 1; i >= 0; i--) begin
      if (elegivel[i]) id_prox = LARGURA_ID'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    carrega_id  = 1'b0;
    aceita      = 1'b0;
    finaliza    = 1'b0;
    case (estado)
      OCIOSO: begin
        if (habilitaInterrupcao && (|elegivel)) begin
          estado_prox = PEDINDO;
          carrega_id  = 1'b1;
        end
      end
      PEDINDO: begin
        if (ackInterrupcao) begin
          estado_prox = TRATANDO;
          aceita      = 1'b1;
        end else if (!habilitaInterrupcao) begin
          estado_prox = OCIOSO;
        end
      end
      TRATANDO: begin
        if (fimInterrupcao) begin
          estado_prox = OCIOSO;
          finaliza    = 1'b1;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // A new edge on the served source survives its own clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_prev <= '0;
      armado   <= 1'b0;
      pendente <= '0;
      mascara  <= '1;
    end else begin
      req_prev <= reqInterrupcao;
      armado   <= 1'b1;
      pendente <= (pendente & ~limpa) | borda;
      if (escreveMascara) mascara <= dadoMascara;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_atual        <= '0;
      valorPCBuffer   <= '0;
      qualInterrupcao <= '0;
    end else begin
      if (carrega_id) id_atual <= id_prox;
      if (aceita) begin
        valorPCBuffer   <= valorPC;
        qualInterrupcao <= 32'(id_atual) + 32'd1;
      end else if (finaliza) begin
        qualInterrupcao <= '0;
      end
    end
  end

  assign pedidoInterrupcao = (estado == PEDINDO);
  assign emTratamento      = (estado == TRATANDO);

endmodule

// File: tb/tb_controlador_interrupcao.sv
// Bench for controlador_interrupcao: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_controlador_interrupcao;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  reqInterrupcao;
  logic        escreveMascara;
  logic [3:0]  dadoMascara;
  logic        habilitaInterrupcao;
  logic [10:0] valorPC;
  logic        ackInterrupcao;
  logic        fimInterrupcao;
  logic        pedidoInterrupcao;
  logic        emTratamento;
  logic [10:0] valorPCBuffer;
  logic [31:0] qualInterrupcao;

  int total = 0;
  int aprovados = 0;

  // Reference model: phase 0 idle, 1 requesting, 2 serving
  int         m_fase;
  int         m_id;
  bit [3:0]   m_pend;
  bit [3:0]   m_masc;
  bit [3:0]   m_prev;
  bit         m_base_ok;
  bit [10:0]  m_pc;
  int         m_qual;

  controlador_interrupcao #(.N_FONTES(4), .LARGURA_PC(11)) dut (
    .clock               (clock),
    .reset               (reset),
    .reqInterrupcao      (reqInterrupcao),
    .escreveMascara      (escreveMascara),
    .dadoMascara         (dadoMascara),
    .habilitaInterrupcao (habilitaInterrupcao),
    .valorPC             (valorPC),
    .ackInterrupcao      (ackInterrupcao),
    .fimInterrupcao      (fimInterrupcao),
    .pedidoInterrupcao   (pedidoInterrupcao),
    .emTratamento        (emTratamento),
    .valorPCBuffer       (valorPCBuffer),
    .qualInterrupcao     (qualInterrupcao)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    assert (obs === esp) aprovados++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, esp);
  endtask

  task automatic modelo_reset();
    m_fase = 0; m_id = 0; m_pend = '0; m_masc = 4'hF;
    m_prev = '0; m_base_ok = 0; m_pc = '0; m_qual = 0;
  endtask

  task automatic modelo_clock();
    bit [3:0] novos;
    bit [3:0] elig;
    novos = m_base_ok ? (reqInterrupcao & ~m_prev) : 4'b0;
    elig  = m_pend & m_masc;
    if (m_fase == 0) begin
      if (habilitaInterrupcao && elig != 0) begin
        for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
        m_fase = 1;
      end
    end else if (m_fase == 1) begin
      if (ackInterrupcao) begin
        m_pc = valorPC;
        m_pend[m_id] = 1'b0;
        m_qual = m_id + 1;
        m_fase = 2;
      end else if (!habilitaInterrupcao) begin
        m_fase = 0;
      end
    end else if (fimInterrupcao) begin
      m_qual = 0;
      m_fase = 0;
    end
    m_pend = m_pend | novos;
    if (escreveMascara) m_masc = dadoMascara;
    m_prev = reqInterrupcao;
    m_base_ok = 1;
  endtask

  task automatic confere(input string tag);
    verifica({tag, "_pedido"}, 32'(pedidoInterrupcao), 32'(m_fase == 1));
    verifica({tag, "_emtrat"}, 32'(emTratamento), 32'(m_fase == 2));
    verifica({tag, "_pcbuf"}, 32'(valorPCBuffer), 32'(m_pc));
    verifica({tag, "_qual"}, qualInterrupcao, 32'(m_qual));
  endtask

  // One clock with the current inputs; reset is checked before the edge too
  task automatic passo(input string tag);
    if (reset) begin
      #1;
      modelo_reset();
      confere({tag, "_async"});
    end
    @(posedge clock);
    if (reset) modelo_reset();
    else       modelo_clock();
    #1;
    confere(tag);
  endtask

  initial begin
    reset = 1'b1; reqInterrupcao = '0; escreveMascara = 0; dadoMascara = '0;
    habilitaInterrupcao = 1; valorPC = '0; ackInterrupcao = 0; fimInterrupcao = 0;
    modelo_reset();
    passo("reset");
    reset = 0;
    passo("idle");

    // Single source, full service round trip
    valorPC = 11'h123;
    reqInterrupcao = 4'b0001; passo("s1_edge");
    verifica("s1_no_pedido_yet", 32'(pedidoInterrupcao), 32'd0);
    passo("s1_pedido");
    verifica("s1_pedido_n2", 32'(pedidoInterrupcao), 32'd1);
    ackInterrupcao = 1; passo("s1_ack"); ackInterrupcao = 0;
    verifica("s1_pc", 32'(valorPCBuffer), 32'h123);
    verifica("s1_qual", qualInterrupcao, 32'd1);
    valorPC = 11'h055;
    fimInterrupcao = 1; passo("s1_fim"); fimInterrupcao = 0;
    verifica("s1_qual_fim", qualInterrupcao, 32'd0);
    verifica("s1_pc_hold", 32'(valorPCBuffer), 32'h123);
    reqInterrupcao = 4'b0000; passo("s1_low");

    // Simultaneous edges on bits 2 and 1: bit 1 served first
    reqInterrupcao = 4'b0110; passo("s2_edge");
    passo("s2_pedido");
    ackInterrupcao = 1; passo("s2_ack1"); ackInterrupcao = 0;
    verifica("s2_first", qualInterrupcao, 32'd2);
    fimInterrupcao = 1; passo("s2_fim1"); fimInterrupcao = 0;
    passo("s2_repedido");
    verifica("s2_repedido_on", 32'(pedidoInterrupcao), 32'd1);
    ackInterrupcao = 1; passo("s2_ack2"); ackInterrupcao = 0;
    verifica("s2_second", qualInterrupcao, 32'd3);
    fimInterrupcao = 1; passo("s2_fim2"); fimInterrupcao = 0;
    reqInterrupcao = 4'b0000; passo("s2_low");

    // Masked source released by a mask write
    escreveMascara = 1; dadoMascara = 4'b1110; passo("s3_wmask"); escreveMascara = 0;
    reqInterrupcao = 4'b0001; passo("s3_edge");
    passo("s3_masked1"); passo("s3_masked2");
    verifica("s3_masked", 32'(pedidoInterrupcao), 32'd0);
    escreveMascara = 1; dadoMascara = 4'b1111; passo("s3_unmask"); escreveMascara = 0;
    passo("s3_pedido");
    verifica("s3_pedido_on", 32'(pedidoInterrupcao), 32'd1);
    ackInterrupcao = 1; passo("s3_ack"); ackInterrupcao = 0;

    // Edge during service waits for fim; bit 0 re-edge coincides with nothing
    reqInterrupcao = 4'b1001; passo("s4_edge3");
    passo("s4_wait1"); passo("s4_wait2");
    verifica("s4_no_nest", 32'(pedidoInterrupcao), 32'd0);
    fimInterrupcao = 1; passo("s4_fim"); fimInterrupcao = 0;
    passo("s4_pedido");
    ackInterrupcao = 1; passo("s4_ack"); ackInterrupcao = 0;
    verifica("s4_qual", qualInterrupcao, 32'd4);
    fimInterrupcao = 1; passo("s4_fim2"); fimInterrupcao = 0;
    reqInterrupcao = 4'b0000; passo("s4_low");

    // Enable dropped while requesting, then restored
    reqInterrupcao = 4'b0100; passo("s5_edge");
    passo("s5_pedido");
    habilitaInterrupcao = 0; passo("s5_drop");
    verifica("s5_idle", 32'(pedidoInterrupcao), 32'd0);
    passo("s5_off");
    habilitaInterrupcao = 1; passo("s5_reen");
    verifica("s5_pedido_again", 32'(pedidoInterrupcao), 32'd1);

    // Set wins over clear: bit 2 re-edges on the ack cycle
    reqInterrupcao = 4'b0000; passo("s6_low");
    reqInterrupcao = 4'b0100; ackInterrupcao = 1; passo("s6_ack"); ackInterrupcao = 0;
    fimInterrupcao = 1; passo("s6_fim"); fimInterrupcao = 0;
    passo("s6_repedido");
    verifica("s6_set_wins", 32'(pedidoInterrupcao), 32'd1);
    ackInterrupcao = 1; passo("s6_ack2"); ackInterrupcao = 0;

    // Reset mid-service with bit 1 held high
    reqInterrupcao = 4'b0010; passo("s7_edge");
    fimInterrupcao = 1; passo("s7_fim"); fimInterrupcao = 0;
    passo("s7_pedido");
    ackInterrupcao = 1; passo("s7_ack"); ackInterrupcao = 0;
    reset = 1; passo("s7_reset"); reset = 0;
    verifica("s7_qual_zero", qualInterrupcao, 32'd0);
    passo("s7_rel1"); passo("s7_rel2"); passo("s7_rel3");
    verifica("s7_no_pedido", 32'(pedidoInterrupcao), 32'd0);
    reqInterrupcao = 4'b0000; passo("s7_fall");
    reqInterrupcao = 4'b0010; passo("s7_rise");
    passo("s7_pedido2");
    verifica("s7_pedido_toggle", 32'(pedidoInterrupcao), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) reqInterrupcao = reqInterrupcao ^ 4'($urandom);
      habilitaInterrupcao = ($urandom_range(0, 7) != 0);
      ackInterrupcao      = ($urandom_range(0, 2) == 0);
      fimInterrupcao      = ($urandom_range(0, 3) == 0);
      escreveMascara      = ($urandom_range(0, 15) == 0);
      dadoMascara         = 4'($urandom);
      valorPC             = 11'($urandom);
      reset               = ($urandom_range(0, 199) == 0);
      passo("rand");
    end
    reset = 0;

    $display("%0d/%0d checks passed", aprovados, total);
    $finish;
  end

endmodule
